// File: rtl/sd_init_sequencer.sv
// ---------------------------------------------------------------------------
// sd_init_sequencer : drives the SPI engine through microSD SPI-mode power-up
// and initialisation.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sd_init_sequencer #(
  parameter int POWERUP_BYTES  = 10,
  parameter int ACMD41_RETRIES = 1000,
  parameter int RESP_TIMEOUT   = 65535,
  parameter int CMD0_RETRIES   = 3
) (
  input  logic        control_clk_i,
  input  logic        control_rst_i,
  input  logic        init_start_i,
  input  logic        spi_done_i,
  input  logic [39:0] spi_resp_i,
  output logic        spi_start_o,
  output logic [47:0] spi_cmd_o,
  output logic        spi_dummy_o,
  output logic        clk_div_sel_o,
  output logic        init_busy_o,
  output logic        init_done_o,
  output logic        init_error_o,
  output logic [2:0]  err_code_o,
  output logic        sdhc_o
);

  localparam int PU_W   = $clog2(POWERUP_BYTES + 1);
  localparam int CMD0_W = $clog2(CMD0_RETRIES + 1);
  localparam int ACMD_W = $clog2(ACMD41_RETRIES + 1);
  localparam int TMO_W  = $clog2(RESP_TIMEOUT + 1);

  localparam logic [47:0] FRAME_DUMMY  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] FRAME_CMD0   = 48'h40_0000_0000_95;
  localparam logic [47:0] FRAME_CMD8   = 48'h48_0000_01AA_87;
  localparam logic [47:0] FRAME_CMD55  = 48'h77_0000_0000_01;
  localparam logic [47:0] FRAME_ACMD41 = 48'h69_4000_0000_01;
  localparam logic [47:0] FRAME_CMD58  = 48'h7A_0000_0000_01;
  localparam logic [47:0] FRAME_CMD16  = 48'h50_0000_0200_01;

  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_CMD0, S_CMD8, S_CMD55,
    S_ACMD41, S_CMD58, S_CMD16, S_DONE, S_ERROR
  } state_t;

  state_t              state, state_next, go_state;
  logic                in_wait, in_wait_next;
  logic                v2, v2_next;
  logic [PU_W-1:0]     pu_cnt, pu_next;
  logic [CMD0_W-1:0]   cmd0_cnt, cmd0_next;
  logic [ACMD_W-1:0]   acmd_cnt, acmd_next, acmd_inc;
  logic [TMO_W-1:0]    tmo_cnt, tmo_next;
  logic                start_next, dummy_next, div_next, busy_next;
  logic                done_next, error_next, sdhc_next;
  logic [2:0]          err_next, fail_code;
  logic [47:0]         cmd_next;
  logic                go, fail;
  logic [7:0]          r1;
  logic [31:0]         payload;
  logic                unused_resp_bits;

  assign r1               = spi_resp_i[39:32];
  assign payload          = spi_resp_i[31:0];
  assign acmd_inc         = acmd_cnt + 1'b1;
  assign unused_resp_bits = ^{payload[31], payload[29:12]};

  function automatic logic [47:0] frame_for(input state_t s);
    case (s)
      S_POWERUP: frame_for = FRAME_DUMMY;
      S_CMD0:    frame_for = FRAME_CMD0;
      S_CMD8:    frame_for = FRAME_CMD8;
      S_CMD55:   frame_for = FRAME_CMD55;
      S_ACMD41:  frame_for = FRAME_ACMD41;
      S_CMD58:   frame_for = FRAME_CMD58;
      S_CMD16:   frame_for = FRAME_CMD16;
      default:   frame_for = 48'h0;
    endcase
  endfunction

  always_comb begin
    state_next   = state;
    in_wait_next = in_wait;
    v2_next      = v2;
    pu_next      = pu_cnt;
    cmd0_next    = cmd0_cnt;
    acmd_next    = acmd_cnt;
    tmo_next     = tmo_cnt;
    start_next   = 1'b0;
    cmd_next     = spi_cmd_o;
    dummy_next   = spi_dummy_o;
    div_next     = clk_div_sel_o;
    busy_next    = init_busy_o;
    done_next    = init_done_o;
    error_next   = init_error_o;
    err_next     = err_code_o;
    sdhc_next    = sdhc_o;
    go           = 1'b0;
    go_state     = state;
    fail         = 1'b0;
    fail_code    = 3'd0;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (init_start_i) begin
          done_next  = 1'b0;
          error_next = 1'b0;
          err_next   = 3'd0;
          sdhc_next  = 1'b0;
          v2_next    = 1'b0;
          pu_next    = '0;
          cmd0_next  = '0;
          acmd_next  = '0;
          busy_next  = 1'b1;
          div_next   = 1'b0;
          dummy_next = 1'b1;
          go         = 1'b1;
          go_state   = S_POWERUP;
        end
      end
      default: begin
        if (!in_wait) begin
          in_wait_next = 1'b1;
          tmo_next     = '0;
        end else if (spi_done_i) begin
          case (state)
            S_POWERUP: begin
              pu_next = pu_cnt + 1'b1;
              go      = 1'b1;
              if (pu_cnt == PU_W'(POWERUP_BYTES - 1)) begin
                dummy_next = 1'b0;
                go_state   = S_CMD0;
              end else begin
                go_state   = S_POWERUP;
              end
            end
            S_CMD0: begin
              if (r1 == 8'h01) begin
                go       = 1'b1;
                go_state = S_CMD8;
              end else if (cmd0_cnt == CMD0_W'(CMD0_RETRIES - 1)) begin
                fail      = 1'b1;
                fail_code = 3'd1;
              end else begin
                cmd0_next = cmd0_cnt + 1'b1;
                go        = 1'b1;
                go_state  = S_CMD0;
              end
            end
            S_CMD8: begin
              if (r1 == 8'h01 && payload[11:0] == 12'h1AA) begin
                v2_next  = 1'b1;
                go       = 1'b1;
                go_state = S_CMD55;
              end else if (r1 == 8'h05) begin
                v2_next  = 1'b0;
                go       = 1'b1;
                go_state = S_CMD55;
              end else begin
                fail      = 1'b1;
                fail_code = 3'd2;
              end
            end
            S_CMD55: begin
              if ((r1 & 8'hFE) == 8'h00) begin
                go       = 1'b1;
                go_state = S_ACMD41;
              end else begin
                fail      = 1'b1;
                fail_code = 3'd3;
              end
            end
            S_ACMD41: begin
              if (r1 == 8'h00) begin
                go       = 1'b1;
                go_state = v2 ? S_CMD58 : S_CMD16;
              end else if (r1 == 8'h01) begin
                // Card still in idle: count the attempt and poll again.
                acmd_next = acmd_inc;
                if (acmd_inc == ACMD_W'(ACMD41_RETRIES)) begin
                  fail      = 1'b1;
                  fail_code = 3'd4;
                end else begin
                  go       = 1'b1;
                  go_state = S_CMD55;
                end
              end else begin
                fail      = 1'b1;
                fail_code = 3'd4;
              end
            end
            S_CMD58: begin
              if (r1 == 8'h00) begin
                sdhc_next = payload[30];
                go        = 1'b1;
                go_state  = payload[30] ? S_DONE : S_CMD16;
              end else begin
                fail      = 1'b1;
                fail_code = 3'd5;
              end
            end
            S_CMD16: begin
              if (r1 == 8'h00) begin
                go       = 1'b1;
                go_state = S_DONE;
              end else begin
                fail      = 1'b1;
                fail_code = 3'd6;
              end
            end
            default: ;
          endcase
        end else if (tmo_cnt == TMO_W'(RESP_TIMEOUT - 1)) begin
          fail      = 1'b1;
          fail_code = 3'd7;
        end else begin
          tmo_next = tmo_cnt + 1'b1;
        end
      end
    endcase

    if (fail) begin
      state_next   = S_ERROR;
      in_wait_next = 1'b0;
      busy_next    = 1'b0;
      error_next   = 1'b1;
      div_next     = 1'b0;
      dummy_next   = 1'b0;
      err_next     = fail_code;
    end else if (go) begin
      in_wait_next = 1'b0;
      state_next   = go_state;
      if (go_state == S_DONE) begin
        busy_next = 1'b0;
        done_next = 1'b1;
        div_next  = 1'b1;
      end else begin
        // Frame is loaded with the state change; the request follows in ISSUE.
        cmd_next   = frame_for(go_state);
        start_next = 1'b1;
      end
    end
  end

  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i) begin
      state         <= S_IDLE;
      in_wait       <= 1'b0;
      v2            <= 1'b0;
      pu_cnt        <= '0;
      cmd0_cnt      <= '0;
      acmd_cnt      <= '0;
      tmo_cnt       <= '0;
      spi_start_o   <= 1'b0;
      spi_cmd_o     <= 48'h0;
      spi_dummy_o   <= 1'b0;
      clk_div_sel_o <= 1'b0;
      init_busy_o   <= 1'b0;
      init_done_o   <= 1'b0;
      init_error_o  <= 1'b0;
      err_code_o    <= 3'd0;
      sdhc_o        <= 1'b0;
    end else begin
      state         <= state_next;
      in_wait       <= in_wait_next;
      v2            <= v2_next;
      pu_cnt        <= pu_next;
      cmd0_cnt      <= cmd0_next;
      acmd_cnt      <= acmd_next;
      tmo_cnt       <= tmo_next;
      spi_start_o   <= start_next;
      spi_cmd_o     <= cmd_next;
      spi_dummy_o   <= dummy_next;
      clk_div_sel_o <= div_next;
      init_busy_o   <= busy_next;
      init_done_o   <= done_next;
      init_error_o  <= error_next;
      err_code_o    <= err_next;
      sdhc_o        <= sdhc_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sd_init_sequencer : randomized microSD card responder with a sequence
// model of the expected command stream and final status.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sd_init_sequencer;

  localparam int BUDGET = 3000;
  localparam logic [48:0] E_DUMMY  = {1'b1, 48'hFFFF_FFFF_FFFF};
  localparam logic [48:0] E_CMD0   = {1'b0, 48'h40_0000_0000_95};
  localparam logic [48:0] E_CMD8   = {1'b0, 48'h48_0000_01AA_87};
  localparam logic [48:0] E_CMD55  = {1'b0, 48'h77_0000_0000_01};
  localparam logic [48:0] E_ACMD41 = {1'b0, 48'h69_4000_0000_01};
  localparam logic [48:0] E_CMD58  = {1'b0, 48'h7A_0000_0000_01};
  localparam logic [48:0] E_CMD16  = {1'b0, 48'h50_0000_0200_01};

  logic        clk;
  logic        rst_n;
  logic        init_start;
  logic        spi_done;
  logic [39:0] spi_resp;
  logic        spi_start;
  logic [47:0] spi_cmd;
  logic        spi_dummy;
  logic        clk_div_sel;
  logic        init_busy;
  logic        init_done;
  logic        init_error;
  logic [2:0]  err_code;
  logic        sdhc;
  logic [57:0] all_outs;

  assign all_outs = {spi_start, spi_cmd, spi_dummy, clk_div_sel, init_busy,
                     init_done, init_error, err_code, sdhc};

  sd_init_sequencer #(
    .POWERUP_BYTES (10),
    .ACMD41_RETRIES(4),
    .RESP_TIMEOUT  (100),
    .CMD0_RETRIES  (3)
  ) dut (
    .control_clk_i(clk),
    .control_rst_i(rst_n),
    .init_start_i (init_start),
    .spi_done_i   (spi_done),
    .spi_resp_i   (spi_resp),
    .spi_start_o  (spi_start),
    .spi_cmd_o    (spi_cmd),
    .spi_dummy_o  (spi_dummy),
    .clk_div_sel_o(clk_div_sel),
    .init_busy_o  (init_busy),
    .init_done_o  (init_done),
    .init_error_o (init_error),
    .err_code_o   (err_code),
    .sdhc_o       (sdhc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int    passed = 0;
  int    total  = 0;
  int    failed = 0;
  int    cyc    = 0;
  string scen   = "";

  // card profile
  int p_cmd0_fails, p_cmd8, p_busy, p_ccs, p_fail, p_withhold, p_poke;
  int cmd0_seen, acmd_seen;

  logic [48:0] act_q[$];
  logic [48:0] exp_q[$];
  int          exp_code;
  int          exp_sdhc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s/%s: observed %0h expected %0h", scen, tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_profile(input int c0, input int c8, input int bz, input int ccs,
                             input int fl, input int wh, input int pk);
    p_cmd0_fails = c0; p_cmd8 = c8; p_busy = bz; p_ccs = ccs;
    p_fail = fl; p_withhold = wh; p_poke = pk;
  endtask

  // Expected command stream and outcome, derived from the protocol rules.
  task automatic model();
    int n;
    exp_q.delete();
    exp_code = 0;
    exp_sdhc = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(E_DUMMY);
    exp_q.push_back(E_CMD0);
    if (p_withhold != 0) begin exp_code = 7; return; end
    n = (p_cmd0_fails >= 3) ? 2 : p_cmd0_fails;
    for (int i = 0; i < n; i++) exp_q.push_back(E_CMD0);
    if (p_cmd0_fails >= 3) begin exp_code = 1; return; end
    exp_q.push_back(E_CMD8);
    if (p_cmd8 == 2) begin exp_code = 2; return; end
    n = (p_busy >= 4) ? 4 : p_busy + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(E_CMD55);
      if (p_fail == 1) begin exp_code = 3; return; end
      exp_q.push_back(E_ACMD41);
    end
    if (p_busy >= 4) begin exp_code = 4; return; end
    if (p_cmd8 == 0) begin
      exp_q.push_back(E_CMD58);
      if (p_fail == 2) begin exp_code = 5; return; end
      exp_sdhc = p_ccs;
      if (p_ccs != 0) return;
    end
    exp_q.push_back(E_CMD16);
    if (p_fail == 3) exp_code = 6;
  endtask

  function automatic logic [39:0] card_resp(input logic dummy, input logic [5:0] idx);
    logic [31:0] pl;
    pl = $urandom;
    if (dummy) return {8'($urandom), pl};
    case (idx)
      6'd0: begin
        cmd0_seen++;
        if (cmd0_seen <= p_cmd0_fails) return {8'($urandom_range(2, 255)), pl};
        return {8'h01, pl};
      end
      6'd8: begin
        if (p_cmd8 == 0) return {8'h01, pl[31:12], 12'h1AA};
        if (p_cmd8 == 1) return {8'h05, pl};
        return {8'h01, pl[31:12], 12'h1AB};
      end
      6'd55: begin
        if (p_fail == 1) return {8'($urandom_range(2, 255)), pl};
        return {8'($urandom_range(0, 1)), pl};
      end
      6'd41: begin
        acmd_seen++;
        return {(acmd_seen <= p_busy) ? 8'h01 : 8'h00, pl};
      end
      6'd58: begin
        if (p_fail == 2) return {8'($urandom_range(1, 255)), pl};
        pl[30] = (p_ccs != 0);
        return {8'h00, pl};
      end
      6'd16: begin
        if (p_fail == 3) return {8'($urandom_range(1, 255)), pl};
        return {8'h00, pl};
      end
      default: return {8'hFF, pl};
    endcase
  endfunction

  task automatic respond(input logic dummy, input logic [5:0] idx);
    logic [39:0] r;
    r = card_resp(dummy, idx);
    // A done pulse during the ISSUE cycle carries a response that would
    // derail the sequence if it were accepted.
    if ($urandom_range(0, 3) == 0) begin
      spi_resp = {8'hFE, 32'hDEAD_BEEF};
      spi_done = 1'b1;
    end
    step();
    spi_done = 1'b0;
    repeat ($urandom_range(0, 4)) step();
    spi_resp   = r;
    spi_done   = 1'b1;
    init_start = (p_poke != 0);
    step();
    spi_done   = 1'b0;
    init_start = 1'b0;
    spi_resp   = 40'({$urandom, $urandom});
  endtask

  task automatic serve(input bit stop_at_cmd8);
    int  s_cyc;
    bit  first;
    bit  withheld;
    logic [5:0] idx;
    first    = 1'b1;
    withheld = 1'b0;
    s_cyc    = 0;
    cyc      = 0;
    cmd0_seen = 0;
    acmd_seen = 0;
    act_q.delete();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    while (1) begin
      if (cyc > BUDGET) begin
        check("cycle_budget_busy", 64'(init_busy), 64'd0);
        break;
      end
      if (!init_busy) break;
      if (spi_start) begin
        if (first) begin
          check("first_start_flags",
                64'({init_busy, clk_div_sel, init_done, init_error, err_code, sdhc}),
                64'h80);
          first = 1'b0;
        end
        act_q.push_back({spi_dummy, spi_cmd});
        idx = spi_cmd[45:40];
        if (stop_at_cmd8 && !spi_dummy && idx == 6'd8) return;
        if (p_withhold != 0 && !spi_dummy && idx == 6'd0 && !withheld) begin
          withheld = 1'b1;
          s_cyc    = cyc;
          step();
          continue;
        end
        respond(spi_dummy, idx);
      end else begin
        step();
      end
    end
    if (withheld)
      check("timeout_latency", 64'((cyc - s_cyc) == 100 || (cyc - s_cyc) == 101), 64'd1);
  endtask

  task automatic final_checks();
    int n;
    check("init_done",   64'(init_done),   64'(exp_code == 0));
    check("init_error",  64'(init_error),  64'(exp_code != 0));
    check("err_code",    64'(err_code),    64'(exp_code));
    check("sdhc",        64'(sdhc),        64'(exp_sdhc));
    check("clk_div_sel", 64'(clk_div_sel), 64'(exp_code == 0));
    check("frame_count", 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("frame[%0d]", i), 64'(act_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run(input string name);
    scen = name;
    model();
    serve(1'b0);
    final_checks();
    repeat (3) step();
  endtask

  initial begin
    bit seen_start;
    bit seen_busy;
    rst_n      = 1'b0;
    init_start = 1'b0;
    spi_done   = 1'b0;
    spi_resp   = 40'h0;

    scen = "reset";
    repeat (2) step();
    check("outputs_in_reset", 64'(all_outs), 64'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_quiet", 64'({spi_start, init_busy}), 64'd0);

    set_profile(0, 0, 2, 1, 0, 0, 0); run("v2_sdhc");
    set_profile(0, 1, 0, 0, 0, 0, 0); run("v1_card");
    set_profile(0, 0, 99, 0, 0, 0, 0); run("acmd41_exhaust");
    set_profile(3, 0, 0, 0, 0, 0, 1); run("cmd0_fail_poke");
    set_profile(0, 0, 0, 0, 0, 1, 0); run("timeout");
    set_profile(0, 0, 1, 0, 0, 0, 0); run("restart_after_timeout");

    // asynchronous reset in the middle of the CMD8 WAIT phase
    scen = "reset_mid_cmd8";
    set_profile(0, 0, 1, 1, 0, 0, 0);
    serve(1'b1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_start = 1'b0;
    seen_busy  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spi_resp = {8'h01, 32'h0000_01AA};
      spi_done = (i == 4);
      step();
      seen_start |= spi_start;
      seen_busy  |= init_busy;
    end
    spi_done = 1'b0;
    check("post_reset_idle", 64'({seen_start, seen_busy}), 64'd0);

    for (int t = 0; t < 8; t++) begin
      set_profile($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 5),
                  $urandom_range(0, 1), $urandom_range(0, 3), 0, $urandom_range(0, 1));
      run($sformatf("random_%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
